// File: rtl/audio_mix_pkg.sv
// Shared types and sizing helpers for the audio voice mixer.
package audio_mix_pkg;

    localparam int unsigned SHIFT_W = 3;
    localparam int unsigned CNT_W   = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SAT   = 2'd2,
        OUT   = 2'd3
    } mix_state_t;

    // Accumulator width that holds the sum of all voices without overflow.
    function automatic int unsigned acc_width(input int unsigned sample_w,
                                              input int unsigned num_voices);
        return sample_w + $clog2(num_voices);
    endfunction

endpackage

// File: rtl/audio_sat.sv
// Combinational signed clamp from the wide accumulator to the DAC sample width.
module audio_sat #(
    parameter int unsigned IN_W  = 18,
    parameter int unsigned OUT_W = 16
) (
    input  logic signed [IN_W-1:0]  din,
    output logic signed [OUT_W-1:0] dout_c
);

    localparam int unsigned TOP_W = IN_W - OUT_W + 1;

    logic [TOP_W-1:0] top_bits;

    // In range when every bit above the output sign bit matches it.
    always_comb begin
        top_bits = din[IN_W-1:OUT_W-1];
        if (top_bits == '0 || top_bits == '1) begin
            dout_c = din[OUT_W-1:0];
        end else if (din[IN_W-1]) begin
            dout_c = {1'b1, {(OUT_W-1){1'b0}}};
        end else begin
            dout_c = {1'b0, {(OUT_W-1){1'b1}}};
        end
    end

endmodule

// File: rtl/audio_mix_sched.sv
// Per-frame voice poller: fetches one sample per enabled voice, attenuates,
// sums, clamps and presents the mono result on both DAC channels.
module audio_mix_sched
    import audio_mix_pkg::*;
#(
    parameter int unsigned NUM_VOICES = 4,
    parameter int unsigned SAMPLE_W   = 16
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_VOICES-1:0]           voice_en,
    input  logic [SHIFT_W*NUM_VOICES-1:0]   voice_shift,
    input  logic [NUM_VOICES-1:0]           voice_valid,
    input  logic [SAMPLE_W*NUM_VOICES-1:0]  voice_data,
    output logic [NUM_VOICES-1:0]           voice_ready,
    input  logic                            mute,
    output logic [SAMPLE_W-1:0]             left_data,
    output logic [SAMPLE_W-1:0]             right_data,
    output logic                            left_valid,
    output logic                            right_valid,
    input  logic                            left_ready,
    input  logic                            right_ready,
    output logic [CNT_W-1:0]                underrun_cnt
);

    localparam int unsigned ACC_W = acc_width(SAMPLE_W, NUM_VOICES);
    localparam int unsigned IDX_W = $clog2(NUM_VOICES);

    mix_state_t                 state;
    logic [IDX_W-1:0]           idx;
    logic signed [ACC_W-1:0]    acc;
    logic signed [SAMPLE_W-1:0] out_data;
    logic                       out_valid;
    logic [CNT_W-1:0]           underrun_q;

    logic signed [SAMPLE_W-1:0] cur_sample;
    logic [SHIFT_W-1:0]         cur_shift;
    logic                       cur_en;
    logic                       cur_valid;
    logic                       fetch_act;
    logic                       accept;
    logic                       underrun_hit;
    logic signed [ACC_W-1:0]    sample_ext;
    logic signed [ACC_W-1:0]    term;
    logic signed [SAMPLE_W-1:0] sat_c;
    logic                       xfer;

    // Select the voice being polled and form its attenuated contribution.
    always_comb begin
        cur_sample = '0;
        cur_shift  = '0;
        cur_en     = 1'b0;
        cur_valid  = 1'b0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (idx == IDX_W'(i)) begin
                cur_sample = voice_data[i*SAMPLE_W +: SAMPLE_W];
                cur_shift  = voice_shift[i*SHIFT_W +: SHIFT_W];
                cur_en     = voice_en[i];
                cur_valid  = voice_valid[i];
            end
        end
        fetch_act    = (state == FETCH) && !reset;
        accept       = fetch_act && cur_en && cur_valid;
        underrun_hit = fetch_act && cur_en && !cur_valid;
        sample_ext   = ACC_W'(cur_sample);
        term         = '0;
        if (accept) begin
            term = sample_ext >>> cur_shift;
        end
        voice_ready = '0;
        if (accept) begin
            voice_ready = NUM_VOICES'(1) << idx;
        end
        xfer = left_ready && right_ready;
    end

    audio_sat #(
        .IN_W  (ACC_W),
        .OUT_W (SAMPLE_W)
    ) u_sat (
        .din    (acc),
        .dout_c (sat_c)
    );

    // Frame sequencer, accumulator, output register and underrun counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            idx        <= '0;
            acc        <= '0;
            out_data   <= '0;
            out_valid  <= 1'b0;
            underrun_q <= '0;
        end else begin
            if (underrun_hit && underrun_q != '1) begin
                underrun_q <= underrun_q + CNT_W'(1);
            end
            case (state)
                IDLE: begin
                    acc   <= '0;
                    idx   <= '0;
                    state <= FETCH;
                end
                FETCH: begin
                    acc <= acc + term;
                    if (idx == IDX_W'(NUM_VOICES - 1)) begin
                        idx   <= '0;
                        state <= SAT;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                SAT: begin
                    out_data  <= mute ? '0 : sat_c;
                    out_valid <= 1'b1;
                    state     <= OUT;
                end
                OUT: begin
                    if (xfer) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign left_data    = out_data;
    assign right_data   = out_data;
    assign left_valid   = out_valid;
    assign right_valid  = out_valid;
    assign underrun_cnt = underrun_q;

endmodule
